// File: rtl/game_pkg.sv
// Shared definitions for the memory game (checker and pattern source).
//   SYM_W          : symbol width of one pattern entry / encoded button
//   state_t        : checker FSM states
//   onehot_to_code : button bank -> symbol (button[i] -> i)
//   is_onehot      : exactly one button pressed
package game_pkg;
  localparam int SYM_W = 2;

  typedef enum logic [2:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, PASS, FAIL} state_t;

  function automatic logic [SYM_W-1:0] onehot_to_code(input logic [3:0] v);
    logic [SYM_W-1:0] c;
    case (v)
      4'b0010: c = SYM_W'(1);
      4'b0100: c = SYM_W'(2);
      4'b1000: c = SYM_W'(3);
      default: c = SYM_W'(0);
    endcase
    return c;
  endfunction

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction
endpackage

// File: rtl/button_checker_if.sv
// Bus between game control / board and the button checker.
//   master : game side, drives start/pattern and the raw buttons
//   slave  : checker side, returns busy, press report and pass/fail
interface button_checker_if;
  import game_pkg::*;
  logic             start;
  logic [1:0]       seq_len;
  logic [SYM_W-1:0] data1, data2, data3;
  logic [3:0]       button;
  logic             busy;
  logic             press_valid;
  logic [SYM_W-1:0] press_code;
  logic [1:0]       idx;
  logic             pass;
  logic             fail;

  modport master (output start, seq_len, data1, data2, data3, button,
                  input  busy, press_valid, press_code, idx, pass, fail);
  modport slave  (input  start, seq_len, data1, data2, data3, button,
                  output busy, press_valid, press_code, idx, pass, fail);
endinterface

// File: rtl/button_sync_edge.sv
// Two-flop synchroniser for the raw button bank plus a one-flop history
// register used for edge detection.
//   clk, rstgame : clock, async active-low reset
//   button       : raw asynchronous buttons
//   sync_val     : synchronised button value
//   press        : bank went from all-released to something pressed
//   rel          : bank is fully released
module button_sync_edge (
  input  logic       clk,
  input  logic       rstgame,
  input  logic [3:0] button,
  output logic [3:0] sync_val,
  output logic       press,
  output logic       rel
);
  logic [3:0] s1, s2, hist;

  always_ff @(posedge clk or negedge rstgame) begin
    if (!rstgame) begin
      s1   <= 4'b0000;
      s2   <= 4'b0000;
      hist <= 4'b0000;
    end else begin
      s1   <= button;
      s2   <= s1;
      hist <= s2;
    end
  end

  assign sync_val = s2;
  // a press needs a fully released bank one cycle earlier, so a held or
  // morphing button never produces a second event
  assign press    = (hist == 4'b0000) && (s2 != 4'b0000);
  assign rel      = (s2 == 4'b0000);
endmodule

// File: rtl/button_checker.sv
// Player-side checker: compares synchronised button presses in order
// against the pattern latched on start and reports pass/fail.
//   clk, rstgame : clock, async active-low reset
//   bus          : start/seq_len/data1..3/button in; busy, press_valid,
//                  press_code, idx, pass, fail out
module button_checker
  import game_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000,
  parameter int TO_W        = 10
) (
  input  logic             clk,
  input  logic             rstgame,
  button_checker_if.slave  bus
);
  state_t                 state, state_n;
  logic [1:0]             idx_r, idx_n, len_r, len_n;
  logic [3:0][SYM_W-1:0]  pat_r, pat_n;
  logic [TO_W-1:0]        cnt_r, cnt_n;
  logic                   pv_r, pv_n, pass_r, pass_n, fail_r, fail_n;
  logic [SYM_W-1:0]       code_r, code_n;
  logic [3:0]             sync_val;
  logic                   press, rel;
  logic [SYM_W-1:0]       code_in;
  logic [1:0]             idx_inc;

  button_sync_edge u_sync (
    .clk      (clk),
    .rstgame  (rstgame),
    .button   (bus.button),
    .sync_val (sync_val),
    .press    (press),
    .rel      (rel)
  );

  assign code_in = onehot_to_code(sync_val);
  assign idx_inc = idx_r + 2'd1;

  always_ff @(posedge clk or negedge rstgame) begin
    if (!rstgame) begin
      state  <= IDLE;
      idx_r  <= '0;
      len_r  <= '0;
      pat_r  <= '0;
      cnt_r  <= '0;
      pv_r   <= 1'b0;
      pass_r <= 1'b0;
      fail_r <= 1'b0;
      code_r <= '0;
    end else begin
      state  <= state_n;
      idx_r  <= idx_n;
      len_r  <= len_n;
      pat_r  <= pat_n;
      cnt_r  <= cnt_n;
      pv_r   <= pv_n;
      pass_r <= pass_n;
      fail_r <= fail_n;
      code_r <= code_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx_r;
    len_n   = len_r;
    pat_n   = pat_r;
    cnt_n   = cnt_r;
    pv_n    = 1'b0;
    pass_n  = pass_r;
    fail_n  = fail_r;
    code_n  = code_r;
    // start beats everything, including a press landing on the same edge
    if (bus.start) begin
      pat_n  = {SYM_W'(0), bus.data3, bus.data2, bus.data1};
      len_n  = bus.seq_len;
      idx_n  = '0;
      pass_n = 1'b0;
      fail_n = 1'b0;
      cnt_n  = '0;
      if (bus.seq_len == 2'd0) begin
        pass_n  = 1'b1;
        state_n = PASS;
      end else begin
        state_n = WAIT_PRESS;
      end
    end else begin
      case (state)
        WAIT_PRESS: begin
          if (press) begin
            if (!is_onehot(sync_val)) begin
              fail_n  = 1'b1;
              state_n = FAIL;
            end else begin
              pv_n   = 1'b1;
              code_n = code_in;
              if (code_in == pat_r[idx_r]) begin
                idx_n = idx_inc;
                if (idx_inc == len_r) begin
                  pass_n  = 1'b1;
                  state_n = PASS;
                end else begin
                  state_n = WAIT_RELEASE;
                end
              end else begin
                fail_n  = 1'b1;
                state_n = FAIL;
              end
            end
          end else if (cnt_r == TO_W'(TIMEOUT_CYC - 1)) begin
            fail_n  = 1'b1;
            state_n = FAIL;
          end else begin
            cnt_n = cnt_r + TO_W'(1);
          end
        end
        WAIT_RELEASE: begin
          if (rel) begin
            cnt_n   = '0;
            state_n = WAIT_PRESS;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state == WAIT_PRESS) || (state == WAIT_RELEASE);
  assign bus.press_valid = pv_r;
  assign bus.press_code  = code_r;
  assign bus.idx         = idx_r;
  assign bus.pass        = pass_r;
  assign bus.fail        = fail_r;
endmodule

// File: doc/button_checker.md
Name: button_checker

Overview:
- Player-side checker for the memory game. It is the receiving end of the pattern that testdata presents on data1..data3.
- It synchronises the 4-bit button bank and encodes each press to a 2-bit symbol. It compares presses in order against the latched pattern and reports pass or fail per stage.
- It sits between the board buttons and the game-control FSM, which issues start and consumes pass/fail.

Parameters:
- SYM_W, 2, symbol width; matches data1..data3.
- TIMEOUT_CYC, 1000, clk cycles allowed in WAIT_PRESS before fail; minimum 2.
- TO_W, 10, timeout counter width; TO_W must satisfy 2**TO_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock; all flops rise-edge.
- rstgame  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches pattern and seq_len, begins checking.
- seq_len  in  2  number of symbols to check, 1..3; 0 = pass immediately.
- data1  in  2  expected symbol 0.
- data2  in  2  expected symbol 1.
- data3  in  2  expected symbol 2.
- button  in  4  raw asynchronous buttons, one-hot when pressed.
- busy  out  1  high in WAIT_PRESS or WAIT_RELEASE.
- press_valid  out  1  one-cycle pulse per accepted press.
- press_code  out  2  encoded symbol of the last press.
- idx  out  2  count of correct presses so far in this stage.
- pass  out  1  level; entire sequence matched.
- fail  out  1  level; mismatch, multi-hot press, or timeout.

Behaviour:
- Reset (rstgame=0, asynchronous): state IDLE; busy=0, press_valid=0, press_code=0, idx=0, pass=0, fail=0; sync flops=4'b0000; timeout counter=0; latched pattern=0.
- Encoding: button[0]->0, [1]->1, [2]->2, [3]->3.
- Synchroniser: 2-flop sync, then a 1-flop history register.
  - Press event = history==4'b0000 and sync output !=4'b0000.
  - Release event = sync output==4'b0000.
- Latency: a button change set up before edge E1 is acted on at edge E3. press_valid, idx, pass and fail become visible after E3.
- FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE, PASS, FAIL.
- IDLE --start--> WAIT_PRESS.
  - Latches data1..3 and seq_len; clears idx, pass, fail and the timeout counter.
  - If seq_len==0, goes directly to PASS instead.
- WAIT_PRESS, press event:
  - Multi-hot value: fail=1, go to FAIL, press_valid=0.
  - One-hot value: press_valid=1, press_code=encoded value.
    - Code == pattern[idx]: idx+1. If idx+1==seq_len, set pass=1 and go to PASS; otherwise go to WAIT_RELEASE.
    - Mismatch: fail=1, go to FAIL, idx unchanged.
- WAIT_PRESS, no press: the timeout counter increments each cycle. When it reaches TIMEOUT_CYC-1 with no press, fail=1 and go to FAIL.
- WAIT_RELEASE, release event: go to WAIT_PRESS and clear the timeout counter.
  - Held buttons never repeat.
  - The timeout counter is frozen in this state.
- PASS and FAIL: hold outputs until start or reset; ignore buttons.
- start in any state, including mid-sequence: immediate restart as from IDLE, using the new pattern.
- Simultaneous start and press event: start wins and the press is dropped.
- Late press: a press arriving while the FSM is in WAIT_RELEASE and buttons never returned to 0 is not detected. A new press needs 0000 first.
- pass and fail are never both 1.

Decomposition:
- game_pkg:
  - SYM_W.
  - State enum {IDLE, WAIT_PRESS, WAIT_RELEASE, PASS, FAIL}.
  - Function onehot_to_code(4b)->2b.
  - Function is_onehot(4b).
  - Shared with testdata.
- Sub-module button_sync_edge: 2-flop sync, history register, press and release outputs, synchronised value.
- button_checker: FSM, pattern latch, timeout counter.

Test Plan:
1. Reset: hold rstgame=0 with button=4'b1111 -> all outputs 0 and state IDLE. Release reset -> still IDLE with no press_valid.
2. Correct 2-symbol pass:
   - start with seq_len=2, data1=1, data2=3.
   - button 0010, then 0000, then 1000 -> two press_valid pulses with press_code 1 then 3, each 3 edges after the input change.
   - idx goes 1 then 2; pass=1 with the second pulse; fail=0.
3. Mismatch: start with seq_len=3, data1=2; press 0001 -> press_valid=1, press_code=0, fail=1, idx=0. A subsequent 0100 press is ignored.
4. Multi-hot: start with seq_len=1; button 0110 -> fail=1 and press_valid never asserts.
5. Timeout:
   - TIMEOUT_CYC=8, start with no buttons -> fail=1 exactly 8 cycles after the start edge.
   - Holding a button in WAIT_RELEASE for 50 cycles -> no fail.
6. Restart mid-operation and reset:
   - After one correct press of 3, pulse start with data1=0 -> idx=0, fail and pass cleared.
   - Drive rstgame=0 mid-sequence -> outputs clear asynchronously, before the next edge.
